// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Default geometry and per-stream state type for the stream
//               prefetch request generator.
// Revision    : 1.0
// ============================================================================
package stream_pkg;

    localparam int C_ADDR_WIDTH   = 64;
    localparam int C_NSTRMS       = 64;
    localparam int C_CL_BYTES     = 128;
    localparam int C_LEN_WIDTH    = 32;
    localparam int C_MAX_CRED     = 4;

    localparam int C_CL_SHIFT     = $clog2(C_CL_BYTES);
    localparam int C_NSTRMS_WIDTH = $clog2(C_NSTRMS);
    localparam int C_CRED_WIDTH   = $clog2(C_MAX_CRED + 1);

    typedef struct packed {
        logic                      active;
        logic [C_ADDR_WIDTH-1:0]   next_ea;
        logic [C_LEN_WIDTH-1:0]    remain;
        logic [C_CRED_WIDTH-1:0]   cred;
    } stream_state_t;

endpackage
`default_nettype wire

// File: rtl/stream_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : stream_rr_arb
// Description : Round-robin arbiter; search begins one past the last grant.
// Revision    : 1.0
// ============================================================================
module stream_rr_arb #(
    parameter int N = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         i_eligible,
    input  logic                 i_advance,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_grant_idx,
    output logic                 o_any_grant
);

    localparam int C_IDX_W = $clog2(N);

    logic [C_IDX_W-1:0] r_ptr;
    int                 w_cand;

    always_comb begin
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_cand      = 0;
        for (int k = 1; k <= N; k++) begin
            w_cand = (int'(r_ptr) + k) % N;
            if (!o_any_grant && i_eligible[C_IDX_W'(w_cand)]) begin
                o_any_grant = 1'b1;
                o_grant_idx = C_IDX_W'(w_cand);
            end
        end
    end

    assign o_grant = {{(N-1){1'b0}}, o_any_grant} << o_grant_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance && o_any_grant) begin
            r_ptr <= o_grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_req_gen.sv
`default_nettype none
// ============================================================================
// Module      : stream_req_gen
// Description : Per-stream credit-throttled cache-line prefetch request issuer.
// Revision    : 1.0
// ============================================================================
module stream_req_gen
    import stream_pkg::*;
#(
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int NSTRMS     = C_NSTRMS,
    parameter int CL_BYTES   = C_CL_BYTES,
    parameter int LEN_WIDTH  = C_LEN_WIDTH,
    parameter int MAX_CRED   = C_MAX_CRED
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_cfg_v,
    output logic                      i_cfg_r,
    input  logic [$clog2(NSTRMS)-1:0] i_cfg_sid,
    input  logic [ADDR_WIDTH-1:0]     i_cfg_ea,
    input  logic [LEN_WIDTH-1:0]      i_cfg_len,
    output logic                      o_req_v,
    input  logic                      o_req_r,
    output logic [$clog2(NSTRMS)-1:0] o_req_sid,
    output logic [ADDR_WIDTH-1:0]     o_req_ea,
    input  logic                      i_cred_v,
    input  logic [$clog2(NSTRMS)-1:0] i_cred_sid,
    output logic                      o_done_v,
    output logic [$clog2(NSTRMS)-1:0] o_done_sid,
    output logic [NSTRMS-1:0]         o_active
);

    localparam int C_SID_W  = $clog2(NSTRMS);
    localparam int C_SHIFT  = $clog2(CL_BYTES);
    localparam int C_CRED_W = $clog2(MAX_CRED + 1);

    logic [NSTRMS-1:0]     r_active;
    logic [ADDR_WIDTH-1:0] r_next_ea [NSTRMS];
    logic [LEN_WIDTH-1:0]  r_remain  [NSTRMS];
    logic [C_CRED_W-1:0]   r_cred    [NSTRMS];

    logic                  r_req_v;
    logic [C_SID_W-1:0]    r_req_sid;
    logic [ADDR_WIDTH-1:0] r_req_ea;
    logic                  r_done_v;
    logic [C_SID_W-1:0]    r_done_sid;

    logic [NSTRMS-1:0]     w_eligible;
    logic [NSTRMS-1:0]     w_grant;
    logic [NSTRMS-1:0]     w_take;
    logic [NSTRMS-1:0]     w_ret;
    logic [C_SID_W-1:0]    w_grant_idx;
    logic                  w_any;
    logic                  w_load;
    logic                  w_advance;
    logic                  w_take_last;
    logic                  w_cfg_fire;
    logic [ADDR_WIDTH-1:0] w_cfg_ea_aligned;
    logic                  w_unused_ea_lsb;

    assign i_cfg_r          = !r_active[i_cfg_sid];
    assign w_cfg_fire       = i_cfg_v && i_cfg_r;
    assign w_cfg_ea_aligned = {i_cfg_ea[ADDR_WIDTH-1:C_SHIFT], {C_SHIFT{1'b0}}};
    assign w_unused_ea_lsb  = ^i_cfg_ea[C_SHIFT-1:0];

    // The output register only advances when empty or being drained.
    assign w_load      = !r_req_v || o_req_r;
    assign w_advance   = w_load && w_any;
    assign w_take      = w_grant & {NSTRMS{w_advance}};
    assign w_take_last = w_advance && (r_remain[w_grant_idx] == LEN_WIDTH'(1));

    always_comb begin
        w_eligible = '0;
        w_ret      = '0;
        for (int s = 0; s < NSTRMS; s++) begin
            w_eligible[s] = r_active[s] && (r_cred[s] != '0);
            w_ret[s]      = i_cred_v && (i_cred_sid == C_SID_W'(s))
                            && (r_cred[s] != C_CRED_W'(MAX_CRED));
        end
    end

    stream_rr_arb #(
        .N (NSTRMS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_eligible  (w_eligible),
        .i_advance   (w_advance),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any)
    );

    // Config only targets idle streams, so it never collides with a take.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NSTRMS; s++) begin
                r_active[s]  <= 1'b0;
                r_next_ea[s] <= '0;
                r_remain[s]  <= '0;
                r_cred[s]    <= C_CRED_W'(MAX_CRED);
            end
        end else begin
            for (int s = 0; s < NSTRMS; s++) begin
                if (w_cfg_fire && (i_cfg_sid == C_SID_W'(s))) begin
                    r_next_ea[s] <= w_cfg_ea_aligned;
                    r_remain[s]  <= i_cfg_len;
                    r_active[s]  <= (i_cfg_len != '0);
                end else if (w_take[s]) begin
                    r_next_ea[s] <= r_next_ea[s] + ADDR_WIDTH'(CL_BYTES);
                    r_remain[s]  <= r_remain[s] - LEN_WIDTH'(1);
                    if (r_remain[s] == LEN_WIDTH'(1)) begin
                        r_active[s] <= 1'b0;
                    end
                end
                case ({w_take[s], w_ret[s]})
                    2'b10:   r_cred[s] <= r_cred[s] - C_CRED_W'(1);
                    2'b01:   r_cred[s] <= r_cred[s] + C_CRED_W'(1);
                    default: r_cred[s] <= r_cred[s];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_v    <= 1'b0;
            r_req_sid  <= '0;
            r_req_ea   <= '0;
            r_done_v   <= 1'b0;
            r_done_sid <= '0;
        end else begin
            if (w_load) begin
                r_req_v <= w_any;
                if (w_any) begin
                    r_req_sid <= w_grant_idx;
                    r_req_ea  <= r_next_ea[w_grant_idx];
                end
            end
            r_done_v <= 1'b0;
            if (w_take_last) begin
                r_done_v   <= 1'b1;
                r_done_sid <= w_grant_idx;
            end else if (w_cfg_fire && (i_cfg_len == '0)) begin
                r_done_v   <= 1'b1;
                r_done_sid <= i_cfg_sid;
            end
        end
    end

    assign o_req_v    = r_req_v;
    assign o_req_sid  = r_req_sid;
    assign o_req_ea   = r_req_ea;
    assign o_done_v   = r_done_v;
    assign o_done_sid = r_done_sid;
    assign o_active   = r_active;

endmodule
`default_nettype wire
